// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT output reorder buffer.
package fft_reorder_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    // Reverse the low 'width' bits of idx; unrolls to pure wiring.
    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) r[i] = idx[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One frame of sample storage: single write port, combinational read port, contents not reset.
module reorder_bank #(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 3,
    localparam int IDX_W  = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [SAMPLES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Reorders one bit-reversed FFT frame into natural order over valid/ready streams.
// Define FFT_REORDER_PINGPONG_EN for two banks (fill while draining); default is one bank.
module fft_output_reorder
    import fft_reorder_pkg::*;
#(
    parameter int SAMPLES = 8,
    parameter int WIDTH   = 3,
    localparam int IDX_W  = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             frame_err
);

`ifdef FFT_REORDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SAMPLES - 1);

    // Handshake: a beat moves only on a cycle where valid && ready; valid never waits on ready.
    logic             wr_fire, rd_fire;
    logic [IDX_W-1:0] wcnt, rcnt, waddr;
    logic             wbank, rbank;
    logic [WIDTH-1:0] rdata [NB];
    bank_state_t      state [NB];
    bank_state_t      state_next [NB];

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign waddr   = IDX_W'(bitrev(32'(wcnt), IDX_W));

    for (genvar g = 0; g < NB; g++) begin : g_bank
        reorder_bank #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wbank == 1'(g))),
            .waddr (waddr),
            .wdata (in_data),
            .raddr (rcnt),
            .rdata (rdata[g])
        );
    end

    // Bank state register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) state[b] <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Write can only hit an EMPTY bank and read only a FULL one, so the two never collide.
    always_comb begin
        state_next = state;
        if (wr_fire && wcnt == LAST) state_next[wbank] = FULL;
        if (rd_fire && rcnt == LAST) state_next[rbank] = EMPTY;
    end

    always_comb begin
        in_ready  = (state[wbank] == EMPTY);
        out_valid = (state[rbank] == FULL);
        out_data  = out_valid ? rdata[rbank] : '0;
        out_index = rcnt;
        out_last  = out_valid && (rcnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= wr_fire && (in_last != (wcnt == LAST));
            if (wr_fire) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
`ifdef FFT_REORDER_PINGPONG_EN
                if (wcnt == LAST) wbank <= ~wbank;
`endif
            end
            if (rd_fire) begin
                rcnt <= (rcnt == LAST) ? '0 : rcnt + 1'b1;
`ifdef FFT_REORDER_PINGPONG_EN
                if (rcnt == LAST) rbank <= ~rbank;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fft_output_reorder.sv
// Directed bench for fft_output_reorder (SAMPLES=8, WIDTH=3), either bank configuration.
module tb_fft_output_reorder;

`ifdef FFT_REORDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_data;
    logic [2:0] out_index;
    logic       out_last;
    logic       frame_err;

    fft_output_reorder #(.SAMPLES(8), .WIDTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [2:0] src_q[$];
    logic       last_q[$];
    logic [2:0] exp_q[$];
    int         exp_idx = 0;
    int         beat = 0;
    logic       err_pend = 1'b0;
    logic       ordy = 1'b1;
    int         outs, accepted, stalls, obs_err;
    logic [2:0] frame [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int brev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // Queue a frame for the driver and its natural-order image for the scoreboard.
    task automatic load_frame(input logic [2:0] d [8], input int last_pos);
        for (int k = 0; k < 8; k++) begin
            src_q.push_back(d[k]);
            last_q.push_back(k == last_pos);
        end
        for (int n = 0; n < 8; n++) exp_q.push_back(d[brev3(n)]);
    endtask

    // One clock: drive at negedge, sample at negedge+1, commit on posedge.
    task automatic tick();
        logic fire_in;
        in_valid  = (src_q.size() > 0);
        in_data   = in_valid ? src_q[0] : 3'd0;
        in_last   = in_valid ? last_q[0] : 1'b0;
        out_ready = ordy;
        #1;
        check("frame_err", 32'(frame_err), 32'(err_pend));
        if (frame_err) obs_err++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0]));
                check("out_index", 32'(out_index), 32'(exp_idx));
                check("out_last", 32'(out_last), 32'(exp_idx == 7));
                void'(exp_q.pop_front());
                exp_idx = (exp_idx + 1) % 8;
                outs++;
            end
        end
        fire_in = in_valid && in_ready;
        if (in_valid && !in_ready) stalls++;
        err_pend = fire_in && (in_last != (beat == 7));
        if (fire_in) beat = (beat + 1) % 8;
        @(posedge clk);
        if (fire_in) begin
            void'(src_q.pop_front());
            void'(last_q.pop_front());
            accepted++;
        end
        @(negedge clk);
    endtask

    task automatic clear_counts();
        outs = 0; accepted = 0; stalls = 0; obs_err = 0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size() + src_q.size()), 0);
    endtask

    initial begin
        int n;
        clear_counts();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single frame, consumer always ready; out = 5,3,6,2,7,1,0,4
        clear_counts();
        frame = '{3'd5, 3'd7, 3'd6, 3'd0, 3'd3, 3'd1, 3'd2, 3'd4};
        load_frame(frame, 7);
        ordy = 1'b1;
        repeat (8) tick();
        check("t1_accepted", 32'(accepted), 8);
        check("t1_latency_valid", 32'(out_valid), 1);
        run_until_idle(40);
        check("t1_outs", 32'(outs), 8);
        check("t1_no_err", 32'(obs_err), 0);

        // 2: stall the consumer for 3 cycles while index 2 is presented
        clear_counts();
        load_frame(frame, 7);
        n = 0;
        while (outs < 2 && n < 40) begin tick(); n++; end
        check("t2_reach", 32'(outs), 2);
        ordy = 1'b0;
        repeat (3) begin
            #1;
            check("t2_hold_valid", 32'(out_valid), 1);
            check("t2_hold_data", 32'(out_data), 6);
            check("t2_hold_index", 32'(out_index), 2);
            tick();
        end
        ordy = 1'b1;
        run_until_idle(40);
        check("t2_outs", 32'(outs), 8);

        // 3: two frames back to back
        clear_counts();
        load_frame(frame, 7);
        frame = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        load_frame(frame, 7);
        run_until_idle(80);
        check("t3_stalls", 32'(stalls), (NB == 2) ? 0 : 8);
        check("t3_outs", 32'(outs), 16);

        // 4: in_last on beat 5 instead of beat 8
        clear_counts();
        frame = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        load_frame(frame, 4);
        run_until_idle(40);
        tick();
        check("t4_err_pulses", 32'(obs_err), 2);
        check("t4_outs", 32'(outs), 8);

        // 5: reset after four beats of a frame
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            src_q.push_back(3'(7 - k));
            last_q.push_back(1'b0);
        end
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        beat = 0; err_pend = 1'b0; exp_idx = 0;
        #1;
        check("t5_in_ready", 32'(in_ready), 1);
        check("t5_out_valid", 32'(out_valid), 0);
        frame = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7, 3'd0};
        load_frame(frame, 7);
        run_until_idle(40);
        check("t5_outs", 32'(outs), 8);

        // 6: consumer blocked; the buffer absorbs NB frames then back-pressures
        clear_counts();
        frame = '{3'd3, 3'd3, 3'd1, 3'd7, 3'd0, 3'd2, 3'd5, 3'd6};
        load_frame(frame, 7);
        frame = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        load_frame(frame, 7);
        frame = '{3'd4, 3'd0, 3'd4, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2};
        load_frame(frame, 7);
        ordy = 1'b0;
        repeat (20) tick();
        #1;
        check("t6_accepted", 32'(accepted), NB * 8);
        check("t6_in_ready", 32'(in_ready), 0);
        check("t6_out_valid", 32'(out_valid), 1);
        check("t6_out_index", 32'(out_index), 0);
        check("t6_out_data", 32'(out_data), 32'(exp_q[0]));
        ordy = 1'b1;
        run_until_idle(120);
        check("t6_outs", 32'(outs), 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
